// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-source buart transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GUARD,
        DRAIN,
        HOLD
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_REQ0 = 2'b01;
    localparam logic [1:0] OWN_REQ1 = 2'b10;

    localparam logic [7:0] LINE_TERM_DEFAULT = 8'h0A;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with read/write pointers and an occupancy count.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one buart transmitter between two byte sources, holding ownership for a
// whole text line so lines never interleave; idle owners lose the lock on timeout.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [7:0]  LINE_TERM    = LINE_TERM_DEFAULT,
    parameter logic [15:0] LOCK_TIMEOUT = 16'd1200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       uart_busy,
    output logic [7:0] tx_data,
    output logic       tx_wr,
    output logic [1:0] owner
);

    arb_state_t  state, next_state;
    logic [1:0]  owner_q, owner_next;
    logic [1:0]  last_owner, last_owner_next;
    logic [15:0] idle_cnt, cnt_next;
    logic        is_term;
    logic        tx_wr_q;
    logic [7:0]  tx_data_q;
    logic        load_issue;
    logic [7:0]  issue_byte;

    logic [7:0]  head0, head1;
    logic        empty0, empty1, full0, full1;
    logic        pop0, pop1;
    logic        own_empty;

    assign req0_ready = ~full0 & ~rst;
    assign req1_ready = ~full1 & ~rst;

    assign pop0 = (state == ISSUE) && (owner_q == OWN_REQ0) && !rst;
    assign pop1 = (state == ISSUE) && (owner_q == OWN_REQ1) && !rst;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (req0_valid & req0_ready),
        .din   (req0_data),
        .pop   (pop0),
        .head  (head0),
        .empty (empty0),
        .full  (full0)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (req1_valid & req1_ready),
        .din   (req1_data),
        .pop   (pop1),
        .head  (head1),
        .empty (empty1),
        .full  (full1)
    );

    assign own_empty  = (owner_q == OWN_REQ1) ? empty1 : empty0;
    assign issue_byte = (owner_next == OWN_REQ1) ? head1 : head0;

    always_comb begin
        next_state      = state;
        owner_next      = owner_q;
        last_owner_next = last_owner;
        cnt_next        = idle_cnt;
        load_issue      = 1'b0;
        case (state)
            IDLE: begin
                // Round-robin on a tie: the requester that did not own last wins.
                if (!empty0 && (empty1 || last_owner == OWN_REQ1)) begin
                    owner_next = OWN_REQ0;
                    load_issue = 1'b1;
                    next_state = ISSUE;
                end else if (!empty1) begin
                    owner_next = OWN_REQ1;
                    load_issue = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = GUARD;
            // buart raises busy one cycle after wr, so busy is not trusted here.
            GUARD: next_state = DRAIN;
            DRAIN: begin
                if (!uart_busy) begin
                    if (is_term) begin
                        last_owner_next = owner_q;
                        owner_next      = OWN_NONE;
                        next_state      = IDLE;
                    end else if (!own_empty) begin
                        load_issue = 1'b1;
                        next_state = ISSUE;
                    end else begin
                        cnt_next   = '0;
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!own_empty) begin
                    load_issue = 1'b1;
                    next_state = ISSUE;
                end else if (idle_cnt == LOCK_TIMEOUT - 16'd1) begin
                    last_owner_next = owner_q;
                    owner_next      = OWN_NONE;
                    next_state      = IDLE;
                end else begin
                    cnt_next = idle_cnt + 16'd1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_q    <= OWN_NONE;
            last_owner <= OWN_REQ1;
            idle_cnt   <= '0;
            is_term    <= 1'b0;
            tx_wr_q    <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state      <= next_state;
            owner_q    <= owner_next;
            last_owner <= last_owner_next;
            idle_cnt   <= cnt_next;
            tx_wr_q    <= load_issue;
            if (load_issue) tx_data_q <= issue_byte;
            if (state == ISSUE) is_term <= (tx_data_q == LINE_TERM);
        end
    end

    // Reset arriving during ISSUE kills the strobe in that same cycle.
    assign tx_wr   = tx_wr_q & ~rst;
    assign tx_data = tx_data_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: latency, line locking, timeout, backpressure, reset, round-robin.
`timescale 1ns/1ps
module tb_uart_tx_arb;

    localparam logic [15:0] T = 16'd1200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req0_data = 8'h00;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req1_data = 8'h00;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic       uart_busy;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic [1:0] owner;

    logic       busy_mode = 1'b0;
    logic       busy_force = 1'b0;
    int         bcnt = 0;
    int         cyc = 0;

    int         n_pass = 0;
    int         n_total = 0;

    logic [9:0] logq[$];
    int         wrcyc[$];

    always #5 clk = ~clk;

    uart_tx_arb #(
        .FIFO_DEPTH   (4),
        .LINE_TERM    (8'h0A),
        .LOCK_TIMEOUT (T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_data  (req0_data),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req1_data  (req1_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .uart_busy  (uart_busy),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .owner      (owner)
    );

    // buart model: busy for 10 cycles after each write strobe.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) bcnt <= 0;
        else if (tx_wr) bcnt <= 10;
        else if (bcnt > 0) bcnt <= bcnt - 1;
    end

    assign uart_busy = busy_mode ? (bcnt != 0) : busy_force;

    always @(negedge clk) begin
        if (tx_wr === 1'b1) begin
            logq.push_back({owner, tx_data});
            wrcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_log(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (logq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(logq.size() >= n), 32'd1);
    endtask

    task automatic check_entry(input string tag, input int idx, input logic [9:0] exp);
        logic [9:0] obs;
        obs = (idx < logq.size()) ? logq[idx] : 10'h3FF;
        check(tag, 32'(obs), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        busy_mode = 1'b0;
        busy_force = 1'b0;
        step(2);
        rst = 1'b0;
        logq.delete();
        wrcyc.delete();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;

        // Reset state
        step(2);
        check("rst_tx_wr", 32'(tx_wr), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        rst = 1'b0;
        step(1);
        check("post_rst_ready0", 32'(req0_ready), 32'd1);
        check("post_rst_ready1", 32'(req1_ready), 32'd1);
        check("post_rst_owner", 32'(owner), 32'd0);

        // Single byte: strobe two cycles after the push cycle
        req0_data = 8'h41; req0_valid = 1'b1;
        step(1);
        req0_valid = 1'b0;
        check("single_c1_wr", 32'(tx_wr), 32'd0);
        step(1);
        check("single_c2_wr", 32'(tx_wr), 32'd1);
        check("single_c2_data", 32'(tx_data), 32'h41);
        check("single_c2_owner", 32'(owner), 32'd1);
        step(1);
        check("single_c3_wr", 32'(tx_wr), 32'd0);
        step(1300);
        check("single_count", 32'(logq.size()), 32'd1);
        check("single_released", 32'(owner), 32'd0);

        // Line lock: both push a full line in the same cycles
        do_reset();
        busy_mode = 1'b1;
        req0_data = 8'h41; req1_data = 8'h78; req0_valid = 1'b1; req1_valid = 1'b1;
        step(1);
        req0_data = 8'h42; req1_data = 8'h79;
        step(1);
        req0_data = 8'h0A; req1_data = 8'h0A;
        step(1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_log(6, 300, "lock_done");
        check_entry("lock_e0", 0, {2'b01, 8'h41});
        check_entry("lock_e1", 1, {2'b01, 8'h42});
        check_entry("lock_e2", 2, {2'b01, 8'h0A});
        check_entry("lock_e3", 3, {2'b10, 8'h78});
        check_entry("lock_e4", 4, {2'b10, 8'h79});
        check_entry("lock_e5", 5, {2'b10, 8'h0A});
        if (wrcyc.size() >= 4) begin
            check("lock_byte_gap", 32'(wrcyc[1] - wrcyc[0]), 32'd12);
            check("lock_switch_gap", 32'(wrcyc[3] - wrcyc[2]), 32'd13);
        end else begin
            check("lock_wrcyc_count", 32'(wrcyc.size()), 32'd6);
        end
        step(20);
        check("lock_released", 32'(owner), 32'd0);

        // Round-robin tie after req1 owned the last line: req0 first
        logq.delete(); wrcyc.delete();
        req0_data = 8'h0A; req1_data = 8'h0A; req0_valid = 1'b1; req1_valid = 1'b1;
        step(1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_log(2, 100, "rr_done");
        check_entry("rr_first", 0, {2'b01, 8'h0A});
        check_entry("rr_second", 1, {2'b10, 8'h0A});
        step(20);

        // Timeout: req0 sends "AB" without a terminator, req1 waits with "z"
        busy_mode = 1'b0; busy_force = 1'b0;
        logq.delete(); wrcyc.delete();
        req0_data = 8'h41; req0_valid = 1'b1;
        step(1);
        req0_data = 8'h42;
        step(1);
        req0_valid = 1'b0;
        check("to_c2_data", 32'(tx_data), 32'h41);
        check("to_c2_owner", 32'(owner), 32'd1);
        step(1);
        req1_data = 8'h7A; req1_valid = 1'b1;
        step(1);
        req1_valid = 1'b0;
        step(1);
        check("to_c5_wr", 32'(tx_wr), 32'd1);
        check("to_c5_data", 32'(tx_data), 32'h42);
        step(595);
        check("to_c600_owner", 32'(owner), 32'd1);
        check("to_c600_count", 32'(logq.size()), 32'd2);
        step(607);
        check("to_c1207_owner", 32'(owner), 32'd1);
        step(1);
        check("to_c1208_owner", 32'(owner), 32'd0);
        check("to_c1208_wr", 32'(tx_wr), 32'd0);
        step(1);
        check("to_c1209_wr", 32'(tx_wr), 32'd1);
        check("to_c1209_data", 32'(tx_data), 32'h7A);
        check("to_c1209_owner", 32'(owner), 32'd2);

        // Backpressure: req0 owns with busy stuck high, req1 pushes 5 bytes
        do_reset();
        busy_force = 1'b1;
        req0_data = 8'h51; req0_valid = 1'b1;
        step(1);
        req0_valid = 1'b0;
        step(1);
        check("bp_c2_data", 32'(tx_data), 32'h51);
        step(1);
        req1_data = 8'h61; req1_valid = 1'b1;
        check("bp_c3_ready", 32'(req1_ready), 32'd1);
        step(1);
        req1_data = 8'h62;
        step(1);
        req1_data = 8'h63;
        step(1);
        req1_data = 8'h64;
        check("bp_c6_ready", 32'(req1_ready), 32'd1);
        step(1);
        req1_data = 8'h65;
        check("bp_c7_full", 32'(req1_ready), 32'd0);
        step(1);
        req0_data = 8'h0A; req0_valid = 1'b1;
        step(1);
        req0_valid = 1'b0;
        step(4);
        check("bp_c13_stall", 32'(req1_ready), 32'd0);
        check("bp_c13_count", 32'(logq.size()), 32'd1);
        busy_force = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (req1_ready) seen = 1'b1;
            else step(1);
        end
        check("bp_ready_return", 32'(seen), 32'd1);
        step(1);
        req1_valid = 1'b0;
        wait_log(7, 300, "bp_done");
        check_entry("bp_e0", 0, {2'b01, 8'h51});
        check_entry("bp_e1", 1, {2'b01, 8'h0A});
        for (int i = 0; i < 5; i++) begin
            check_entry("bp_req1", 2 + i, {2'b10, 8'(8'h61 + i)});
        end

        // Reset mid-line during GUARD with two bytes still queued
        do_reset();
        req0_data = 8'hC1; req0_valid = 1'b1;
        step(1);
        req0_data = 8'hC2;
        step(1);
        req0_data = 8'hC3;
        check("rml_c2_data", 32'(tx_data), 32'hC1);
        step(1);
        req0_valid = 1'b0;
        check("rml_c3_wr", 32'(tx_wr), 32'd0);
        rst = 1'b1;
        step(1);
        check("rml_rst_wr", 32'(tx_wr), 32'd0);
        check("rml_rst_owner", 32'(owner), 32'd0);
        rst = 1'b0;
        logq.delete(); wrcyc.delete();
        step(10);
        check("rml_no_stale", 32'(logq.size()), 32'd0);
        check("rml_ready0", 32'(req0_ready), 32'd1);
        req0_data = 8'h31; req0_valid = 1'b1;
        step(1);
        req0_valid = 1'b0;
        check("rml_n1_wr", 32'(tx_wr), 32'd0);
        step(1);
        check("rml_n2_wr", 32'(tx_wr), 32'd1);
        check("rml_n2_data", 32'(tx_data), 32'h31);
        step(10);
        check("rml_only_one", 32'(logq.size()), 32'd1);

        // Reset asserted during ISSUE cancels the strobe
        do_reset();
        req0_data = 8'h55; req0_valid = 1'b1;
        step(1);
        req0_valid = 1'b0;
        step(1);
        check("ri_wr_before", 32'(tx_wr), 32'd1);
        rst = 1'b1;
        #1;
        check("ri_wr_cancel", 32'(tx_wr), 32'd0);
        step(1);
        rst = 1'b0;
        step(5);
        check("ri_after_wr", 32'(tx_wr), 32'd0);
        check("ri_after_owner", 32'(owner), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
